// File: rtl/ips2l_pcie_dma_mwr_payload_rd_engine.sv
// MWr payload read engine.
// Fetches TLP payload beats from BAR RAM, buffers them in a small prefetch
// FIFO and streams them to the MWr TLP builder with a per-beat DW mask.
// RAM reads are credit limited: a read is issued only when the FIFO has room
// for everything already in flight, so the FIFO can never overflow.
module ips2l_pcie_dma_mwr_payload_rd_engine #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 9,
    parameter int RAM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_rd_en,
    input  logic [9:0]              i_rd_length,
    input  logic [ADDR_WIDTH-1:0]   i_rd_start_addr,
    input  logic                    i_mwr_tx_busy,
    input  logic                    i_mwr_tx_hold,
    output logic                    o_gen_tlp_start,
    output logic                    o_rd_valid,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic [DATA_WIDTH/32-1:0] o_rd_dw_en,
    output logic                    o_last_data,
    output logic                    o_busy,
    output logic                    o_bar_rd_clk_en,
    output logic [ADDR_WIDTH-1:0]   o_bar_rd_addr,
    input  logic [DATA_WIDTH-1:0]   i_bar_rd_data
);

    localparam int DPB  = DATA_WIDTH / 32;
    localparam int LDPB = $clog2(DPB);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_rd_en_ff;
    logic [10:0]             r_issue_rem;
    logic [10:0]             r_beats;
    logic [LDPB-1:0]         r_rem;
    logic [ADDR_WIDTH-1:0]   r_next_addr;
    logic [ADDR_WIDTH-1:0]   r_bar_addr;
    logic                    r_clk_en;
    logic [CW-1:0]           r_inflight;
    logic [RAM_LATENCY-1:0]  r_vld_sr;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic [10:0]             r_head_idx;
    logic                    r_first_seen;
    logic                    r_tlp_start;

    logic                    w_rd_start;
    logic [10:0]             w_len;
    logic [10:0]             w_beats;
    logic [CW:0]             w_credit;
    logic                    w_issue;
    logic                    w_land;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rd_valid;
    logic                    w_last;
    logic [DPB-1:0]          w_mask;

    // A transfer only starts on a fresh rd_en edge, from IDLE, while the MWr path is up.
    assign w_rd_start = i_rd_en & ~r_rd_en_ff & (r_state == S_IDLE) & i_mwr_tx_busy;
    assign w_len      = (i_rd_length == 10'd0) ? 11'd1024 : {1'b0, i_rd_length};
    assign w_beats    = (w_len + 11'(DPB - 1)) >> LDPB;

    // Credit: FIFO occupancy plus reads still in the RAM pipe must leave room for one more.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue    = (r_state == S_FETCH) && (r_issue_rem != 11'd0) && (w_credit < DEPTH_C);

    assign w_land     = r_vld_sr[RAM_LATENCY-1];
    assign w_push     = w_land;
    assign w_rd_valid = (r_count != '0);
    assign w_pop      = w_rd_valid && !i_mwr_tx_hold;
    assign w_last     = w_rd_valid && (r_head_idx == r_beats - 11'd1);
    assign w_mask     = (w_last && r_rem != '0) ? ~({DPB{1'b1}} << r_rem) : {DPB{1'b1}};

    assign o_rd_valid      = w_rd_valid;
    assign o_rd_data       = w_rd_valid ? r_mem[r_rptr] : '0;
    assign o_rd_dw_en      = w_rd_valid ? w_mask : '0;
    assign o_last_data     = w_last;
    assign o_busy          = (r_state != S_IDLE);
    assign o_bar_rd_clk_en = r_clk_en;
    assign o_bar_rd_addr   = r_bar_addr;
    assign o_gen_tlp_start = r_tlp_start;

    // Previous rd_en level for edge detection; tracked in every state so a held level never retriggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_en_ff <= 1'b0;
        else        r_rd_en_ff <= i_rd_en;
    end

    // Transfer FSM: read issue, address walk, head-beat tracking and tlp_start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_issue_rem  <= '0;
            r_beats      <= '0;
            r_rem        <= '0;
            r_next_addr  <= '0;
            r_bar_addr   <= '0;
            r_clk_en     <= 1'b0;
            r_head_idx   <= '0;
            r_first_seen <= 1'b0;
            r_tlp_start  <= 1'b0;
        end else if (!i_mwr_tx_busy) begin
            r_state      <= S_IDLE;
            r_issue_rem  <= '0;
            r_clk_en     <= 1'b0;
            r_head_idx   <= '0;
            r_first_seen <= 1'b0;
            r_tlp_start  <= 1'b0;
        end else begin
            r_tlp_start <= 1'b0;
            r_clk_en    <= w_issue;
            if (w_issue) begin
                r_bar_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                r_issue_rem <= r_issue_rem - 11'd1;
            end
            // First landing beat becomes visible on o_rd_valid next cycle, together with this pulse.
            if (w_push && !r_first_seen) begin
                r_first_seen <= 1'b1;
                r_tlp_start  <= 1'b1;
            end
            if (w_pop) r_head_idx <= r_head_idx + 11'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_start) begin
                        r_state      <= S_FETCH;
                        r_beats      <= w_beats;
                        r_issue_rem  <= w_beats;
                        r_rem        <= w_len[LDPB-1:0];
                        r_next_addr  <= i_rd_start_addr;
                        r_head_idx   <= '0;
                        r_first_seen <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w_issue && r_issue_rem == 11'd1) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && w_last) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM return tracking; clearing the valid pipe on abort discards late returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr   <= '0;
            r_inflight <= '0;
        end else if (!i_mwr_tx_busy) begin
            r_vld_sr   <= '0;
            r_inflight <= '0;
        end else begin
            r_vld_sr[0] <= r_clk_en;
            for (int i = 1; i < RAM_LATENCY; i++) r_vld_sr[i] <= r_vld_sr[i-1];
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_land);
        end
    end

    // Prefetch FIFO pointers and occupancy; flushed on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (!i_mwr_tx_busy) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_bar_rd_data;
    end

    // The credit rule must keep a landing beat from ever hitting a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n && i_mwr_tx_busy)
            assert (!(w_push && !w_pop && r_count == FULL_C));
    end

endmodule

// File: tb/tb_ips2l_pcie_dma_mwr_payload_rd_engine.sv
// Directed bench for the MWr payload read engine with a 1-cycle BAR RAM model.
module tb_ips2l_pcie_dma_mwr_payload_rd_engine;

    localparam int DW = 128;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_rd_en = 1'b0;
    logic [9:0]    i_rd_length = '0;
    logic [AW-1:0] i_rd_start_addr = '0;
    logic          i_mwr_tx_busy = 1'b1;
    logic          i_mwr_tx_hold = 1'b0;
    logic          o_gen_tlp_start;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic [3:0]    o_rd_dw_en;
    logic          o_last_data;
    logic          o_busy;
    logic          o_bar_rd_clk_en;
    logic [AW-1:0] o_bar_rd_addr;
    logic [DW-1:0] ram_q = '0;

    int checks = 0;
    int failures = 0;

    ips2l_pcie_dma_mwr_payload_rd_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rd_en(i_rd_en), .i_rd_length(i_rd_length), .i_rd_start_addr(i_rd_start_addr),
        .i_mwr_tx_busy(i_mwr_tx_busy), .i_mwr_tx_hold(i_mwr_tx_hold),
        .o_gen_tlp_start(o_gen_tlp_start), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_rd_dw_en(o_rd_dw_en), .o_last_data(o_last_data), .o_busy(o_busy),
        .o_bar_rd_clk_en(o_bar_rd_clk_en), .o_bar_rd_addr(o_bar_rd_addr),
        .i_bar_rd_data(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ramd(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < 4; k++) d[32*k +: 32] = {8'h5A, 7'd0, a, 8'(k)};
        return d;
    endfunction

    // BAR RAM: one beat returned one cycle after each enabled read.
    always @(posedge clk) if (o_bar_rd_clk_en) ram_q <= ramd(o_bar_rd_addr);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer to completion, checking issue addresses, latency and every popped beat.
    task automatic run_xfer(input int len, input logic [AW-1:0] addr, input int hold_n, input int exp_held);
        int n, beats, r, idx, issued, starts, cyc, first, first_iss;
        bit done, hold;
        logic [AW-1:0] ea;
        logic [3:0] em;
        n = (len == 0) ? 1024 : len;
        beats = (n + 3) / 4;
        r = n % 4;
        i_rd_en = 1'b0;
        tick;
        i_rd_en = 1'b1;
        i_rd_length = 10'(len);
        i_rd_start_addr = addr;
        idx = 0; issued = 0; starts = 0; cyc = 0; first = -1; first_iss = -1; done = 1'b0;
        while (!done && cyc < 4000) begin
            tick;
            cyc++;
            if (o_bar_rd_clk_en) begin
                ea = addr + AW'(issued);
                chk("rd_addr", o_bar_rd_addr, ea);
                if (first_iss < 0) first_iss = cyc;
                issued++;
            end
            if (o_gen_tlp_start) starts++;
            if (o_rd_valid && first < 0) begin
                first = cyc;
                chk("tlp_start_first", o_gen_tlp_start, 1);
                chk("first_issue_lat", first_iss, 2);
                chk("first_valid_lat", first, 4);
            end
            hold = (first >= 0) && (cyc < first + hold_n);
            i_mwr_tx_hold = hold;
            if (hold_n > 0 && first >= 0 && cyc == first + hold_n - 1) begin
                chk("issued_while_held", issued, exp_held);
                chk("clk_en_stalled", o_bar_rd_clk_en, 0);
            end
            if (o_rd_valid && !hold) begin
                ea = addr + AW'(idx);
                em = (idx == beats - 1 && r != 0) ? 4'((1 << r) - 1) : 4'hF;
                chk("beat_data", o_rd_data, ramd(ea));
                chk("beat_dw_en", o_rd_dw_en, em);
                chk("beat_last", o_last_data, (idx == beats - 1));
                if (idx == beats - 1) done = 1'b1;
                idx++;
            end
        end
        i_mwr_tx_hold = 1'b0;
        chk("xfer_done", done, 1);
        tick;
        chk("busy_after", o_busy, 0);
        chk("valid_after", o_rd_valid, 0);
        chk("tlp_start_count", starts, 1);
        chk("beat_count", idx, beats);
        chk("issue_count", issued, beats);
    endtask

    initial begin
        int w;
        // Reset state
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_rd_valid, 0);
        chk("rst_clk_en", o_bar_rd_clk_en, 0);
        chk("rst_addr", o_bar_rd_addr, 0);
        chk("rst_tlp_start", o_gen_tlp_start, 0);
        chk("rst_data", o_rd_data, 0);
        chk("rst_dw_en", o_rd_dw_en, 0);
        chk("rst_last", o_last_data, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // T1: two full beats from 0x10
        run_xfer(8, 9'h010, 0, 0);
        tick; tick; tick;
        chk("no_retrigger_busy", o_busy, 0);
        chk("no_retrigger_clk_en", o_bar_rd_clk_en, 0);

        // T2: partial last beat, then maximum length
        run_xfer(5, 9'h030, 0, 0);
        run_xfer(0, 9'h100, 0, 0);

        // T3: downstream stall caps outstanding reads at the FIFO depth
        run_xfer(64, 9'h050, 10, 4);

        // T4: address wrap
        run_xfer(16, 9'h1FE, 0, 0);

        // T5: abort via tx_busy low for one cycle
        i_rd_en = 1'b0;
        tick;
        i_rd_en = 1'b1;
        i_rd_length = 10'd64;
        i_rd_start_addr = 9'h080;
        w = 0;
        while (!o_rd_valid && w < 20) begin tick; w++; end
        chk("abort_reached_valid", o_rd_valid, 1);
        i_mwr_tx_busy = 1'b0;
        tick;
        i_mwr_tx_busy = 1'b1;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_rd_valid, 0);
        chk("abort_clk_en", o_bar_rd_clk_en, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort_late_valid", o_rd_valid, 0);
            chk("abort_late_busy", o_busy, 0);
        end
        run_xfer(8, 9'h020, 0, 0);

        // T6: asynchronous reset mid-FETCH
        i_rd_en = 1'b0;
        tick;
        i_rd_en = 1'b1;
        i_rd_length = 10'd64;
        i_rd_start_addr = 9'h000;
        tick; tick;
        chk("pre_reset_clk_en", o_bar_rd_clk_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_clk_en", o_bar_rd_clk_en, 0);
        chk("arst_addr", o_bar_rd_addr, 0);
        chk("arst_valid", o_rd_valid, 0);
        chk("arst_tlp_start", o_gen_tlp_start, 0);
        i_rd_en = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("post_reset_busy", o_busy, 0);

        // rd_en edge during DRAIN is ignored
        i_mwr_tx_hold = 1'b1;
        i_rd_en = 1'b1;
        i_rd_length = 10'd8;
        i_rd_start_addr = 9'h040;
        tick;
        tick; tick; tick; tick;
        chk("drain_busy", o_busy, 1);
        chk("drain_valid", o_rd_valid, 1);
        i_rd_en = 1'b0;
        tick;
        i_rd_en = 1'b1;
        tick;
        chk("drain_still_busy", o_busy, 1);
        chk("drain_beat0", o_rd_data, ramd(9'h040));
        i_mwr_tx_hold = 1'b0;
        repeat (6) tick;
        chk("drain_edge_ignored_busy", o_busy, 0);
        chk("drain_edge_ignored_clk_en", o_bar_rd_clk_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
